// File: rtl/fpu_seq_pkg.sv
// rtl/fpu_seq_pkg.sv - shared types and default widths for the FPU config sequencer
package fpu_seq_pkg;
  localparam int NUM_CTX_DEF = 8;
  localparam int CB1_W       = 16 * 4;
  localparam int CB2_W       = 4 * 4;
  localparam int INST_W      = 64;
  localparam int LEN_W       = 8;

  typedef struct packed {
    logic [CB1_W-1:0]  cb1;
    logic [CB2_W-1:0]  cb2;
    logic [INST_W-1:0] inst;
    logic [LEN_W-1:0]  len;
    logic              last;
  } ctx_t;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
endpackage

// File: rtl/fpu_seq_ctx_mem.sv
// rtl/fpu_seq_ctx_mem.sv - context register file, one sync write port, one comb read port
module fpu_seq_ctx_mem
  import fpu_seq_pkg::*;
#(
  parameter int NUM_CTX = 8,
  parameter int AW      = $clog2(NUM_CTX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  ctx_t          wr_data,
  input  logic [AW-1:0] rd_addr,
  output ctx_t          rd_data
);
  ctx_t mem [NUM_CTX];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CTX; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fpu_config_sequencer.sv
// rtl/fpu_config_sequencer.sv - context sequencer for the FPU tile; FPU_SEQ_LOOP_EN adds program looping
module fpu_config_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int NUM_CTX         = 8,
  parameter int NUM_OUTPUTS_CB1 = 16,
  parameter int SEL_WIDTH_CB1   = 4,
  parameter int NUM_OUTPUTS_CB2 = 4,
  parameter int SEL_WIDTH_CB2   = 4,
  parameter int INST_WIDTH      = 64,
  parameter int LEN_WIDTH       = 8,
  parameter int FU_LAT          = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     cfg_wr_valid,
  output logic                                     cfg_wr_ready,
  input  logic [$clog2(NUM_CTX)-1:0]               cfg_wr_addr,
  input  logic [NUM_OUTPUTS_CB1*SEL_WIDTH_CB1-1:0] cfg_wr_cb1,
  input  logic [NUM_OUTPUTS_CB2*SEL_WIDTH_CB2-1:0] cfg_wr_cb2,
  input  logic [INST_WIDTH-1:0]                    cfg_wr_inst,
  input  logic [LEN_WIDTH-1:0]                     cfg_wr_len,
  input  logic                                     cfg_wr_last,
  input  logic                                     start,
  input  logic [$clog2(NUM_CTX)-1:0]               start_ctx,
`ifdef FPU_SEQ_LOOP_EN
  input  logic [LEN_WIDTH-1:0]                     loop_cnt,
`endif
  input  logic                                     abort,
  output logic                                     busy,
  output logic                                     done,
  output logic [$clog2(NUM_CTX)-1:0]               ctx_idx_o,
  output logic [NUM_OUTPUTS_CB1*SEL_WIDTH_CB1-1:0] config_cb1_o,
  output logic [INST_WIDTH-1:0]                    config_all_o,
  output logic                                     cb1_en_o,
  output logic [NUM_OUTPUTS_CB2*SEL_WIDTH_CB2-1:0] config_cb2_o,
  output logic                                     cb2_en_o
);
  localparam int AW   = $clog2(NUM_CTX);
  localparam int CB2W = NUM_OUTPUTS_CB2 * SEL_WIDTH_CB2;
  localparam int DW   = $clog2(FU_LAT + 1);

  state_t               state, state_d;
  ctx_t                 wr_ctx, rd_ctx;
  logic [AW-1:0]        rd_addr, base_ctx;
  logic [LEN_WIDTH-1:0] hold_cnt;
  logic                 cur_last, load_ctx, done_d, loop_more, loop_back, flush;
  logic [CB2W-1:0]      cur_cb2;
  logic [DW-1:0]        drain_cnt;
  logic [FU_LAT-1:0]    en_pipe;
  logic [CB2W-1:0]      cb2_pipe [FU_LAT];

  assign wr_ctx = '{cb1: cfg_wr_cb1, cb2: cfg_wr_cb2, inst: cfg_wr_inst,
                    len: cfg_wr_len, last: cfg_wr_last};
  assign cfg_wr_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign flush        = abort && (state != IDLE);

  fpu_seq_ctx_mem #(.NUM_CTX(NUM_CTX), .AW(AW)) u_ctx_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cfg_wr_valid && cfg_wr_ready),
    .wr_addr (cfg_wr_addr),
    .wr_data (wr_ctx),
    .rd_addr (rd_addr),
    .rd_data (rd_ctx)
  );

`ifdef FPU_SEQ_LOOP_EN
  logic [LEN_WIDTH-1:0] loop_q, iter_q;
  assign loop_more = (iter_q < loop_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_q <= '0;
      iter_q <= '0;
    end else if (state == IDLE && start && !abort) begin
      loop_q <= loop_cnt;
      iter_q <= '0;
    end else if (loop_back) begin
      iter_q <= iter_q + 1'b1;
    end
  end
`else
  assign loop_more = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next context is fetched combinationally so a context switch costs no bubble.
  always_comb begin
    state_d   = state;
    load_ctx  = 1'b0;
    loop_back = 1'b0;
    done_d    = 1'b0;
    rd_addr   = ctx_idx_o + 1'b1;
    case (state)
      IDLE:  if (start && !abort) state_d = LOAD;
      LOAD: begin
        if (abort) state_d = IDLE;
        else begin
          rd_addr  = base_ctx;
          load_ctx = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (abort) state_d = IDLE;
        else if (hold_cnt == '0) begin
          if (!cur_last) load_ctx = 1'b1;
          else if (loop_more) begin
            rd_addr   = base_ctx;
            load_ctx  = 1'b1;
            loop_back = 1'b1;
          end else state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) state_d = IDLE;
        else if (drain_cnt == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done         <= 1'b0;
      cb1_en_o     <= 1'b0;
      ctx_idx_o    <= '0;
      config_cb1_o <= '0;
      config_all_o <= '0;
      cur_cb2      <= '0;
      cur_last     <= 1'b0;
      hold_cnt     <= '0;
      base_ctx     <= '0;
      drain_cnt    <= '0;
    end else begin
      done     <= done_d;
      cb1_en_o <= (state_d == RUN);
      if (state == IDLE && start && !abort) base_ctx <= start_ctx;
      if (load_ctx) begin
        ctx_idx_o    <= rd_addr;
        config_cb1_o <= rd_ctx.cb1;
        config_all_o <= rd_ctx.inst;
        cur_cb2      <= rd_ctx.cb2;
        cur_last     <= rd_ctx.last;
        hold_cnt     <= rd_ctx.len;
      end else if (state == RUN && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      if (state == RUN && state_d == DRAIN) drain_cnt <= DW'(FU_LAT - 1);
      else if (state == DRAIN)              drain_cnt <= drain_cnt - 1'b1;
    end
  end

  // cb2 side trails cb1 by FU_LAT so selects line up with FU results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_pipe <= '0;
      for (int i = 0; i < FU_LAT; i++) cb2_pipe[i] <= '0;
    end else begin
      cb2_pipe[0] <= cur_cb2;
      for (int i = 1; i < FU_LAT; i++) cb2_pipe[i] <= cb2_pipe[i-1];
      if (flush) en_pipe <= '0;
      else begin
        en_pipe[0] <= cb1_en_o;
        for (int i = 1; i < FU_LAT; i++) en_pipe[i] <= en_pipe[i-1];
      end
    end
  end

  assign cb2_en_o     = en_pipe[FU_LAT-1];
  assign config_cb2_o = cb2_pipe[FU_LAT-1];
endmodule

// File: tb/tb_fpu_config_sequencer.sv
// tb/tb_fpu_config_sequencer.sv - randomized bench with a schedule-based model of the sequencer
module tb_fpu_config_sequencer;
  localparam int NC = 8, FL = 2, MAXC = 6000;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cfg_wr_valid = 0, cfg_wr_ready, cfg_wr_last = 0, start = 0, abort = 0;
  logic [2:0]  cfg_wr_addr = 0, start_ctx = 0, ctx_idx_o;
  logic [63:0] cfg_wr_cb1 = 0, cfg_wr_inst = 0, config_cb1_o, config_all_o;
  logic [15:0] cfg_wr_cb2 = 0, config_cb2_o;
  logic [7:0]  cfg_wr_len = 0;
  logic        busy, done, cb1_en_o, cb2_en_o;
`ifdef FPU_SEQ_LOOP_EN
  logic [7:0]  loop_cnt = 0;
`endif

  fpu_config_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(cfg_wr_ready),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_cb1(cfg_wr_cb1), .cfg_wr_cb2(cfg_wr_cb2),
    .cfg_wr_inst(cfg_wr_inst), .cfg_wr_len(cfg_wr_len), .cfg_wr_last(cfg_wr_last),
    .start(start), .start_ctx(start_ctx),
`ifdef FPU_SEQ_LOOP_EN
    .loop_cnt(loop_cnt),
`endif
    .abort(abort), .busy(busy), .done(done), .ctx_idx_o(ctx_idx_o),
    .config_cb1_o(config_cb1_o), .config_all_o(config_all_o), .cb1_en_o(cb1_en_o),
    .config_cb2_o(config_cb2_o), .cb2_en_o(cb2_en_o));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-cycle outputs, filled as whole schedules when a start is accepted.
  bit          e_busy [MAXC], e_done [MAXC], e_en1 [MAXC], e_en2 [MAXC];
  int          e_idx  [MAXC];
  logic [63:0] e_c1 [MAXC], e_inst [MAXC];
  logic [15:0] e_c2 [MAXC];
  bit          o_busy [MAXC], o_done [MAXC], o_en1 [MAXC], o_en2 [MAXC], o_rdy [MAXC];
  int          o_idx  [MAXC];
  logic [63:0] m_c1 [NC], m_inst [NC];
  logic [15:0] m_c2 [NC];
  int          m_len [NC];
  bit          m_last [NC];
  int          n_tests = 0, n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0 && cyc < MAXC) begin
      o_busy[cyc] = busy; o_done[cyc] = done; o_en1[cyc] = cb1_en_o;
      o_en2[cyc] = cb2_en_o; o_rdy[cyc] = cfg_wr_ready; o_idx[cyc] = int'(ctx_idx_o);
      chk("busy", busy, e_busy[cyc]);
      chk("done", done, e_done[cyc]);
      chk("ready", cfg_wr_ready, !e_busy[cyc]);
      chk("cb1_en", cb1_en_o, e_en1[cyc]);
      chk("cb2_en", cb2_en_o, e_en2[cyc]);
      chk("ctx_idx", ctx_idx_o, e_idx[cyc]);
      chk("cfg_cb1", config_cb1_o, e_c1[cyc]);
      chk("cfg_inst", config_all_o, e_inst[cyc]);
      if (e_en2[cyc]) chk("cfg_cb2", config_cb2_o, e_c2[cyc]);
    end
  end

  function automatic void hold_from(int f, bit keep_busy);
    for (int c = f; c < MAXC; c++) begin
      if (!keep_busy) e_busy[c] = 0;
      e_done[c] = 0; e_en1[c] = 0; e_en2[c] = 0;
      e_idx[c] = e_idx[f-1]; e_c1[c] = e_c1[f-1]; e_inst[c] = e_inst[f-1];
    end
  endfunction

  // Walk the program: each context shows for len+1 cycles, cb2 trails by FL, then drain and done.
  function automatic void gen(int t, int sc, int loops);
    int c = t + 2, idx = sc, iter = 0;
    bit fin = 0;
    hold_from(t + 1, 0);
    e_busy[t+1] = 1;
    while (c < MAXC - FL - 2 && !fin) begin
      for (int k = 0; k <= m_len[idx] && c < MAXC - FL - 2; k++) begin
        e_busy[c] = 1; e_en1[c] = 1; e_idx[c] = idx; e_c1[c] = m_c1[idx]; e_inst[c] = m_inst[idx];
        e_en2[c+FL] = 1; e_c2[c+FL] = m_c2[idx];
        c++;
      end
      if (!m_last[idx]) idx = (idx + 1) % NC;
      else if (iter < loops) begin iter++; idx = sc; end
      else fin = 1;
    end
    for (int cc = c; cc < MAXC; cc++) begin
      e_idx[cc] = e_idx[c-1]; e_c1[cc] = e_c1[c-1]; e_inst[cc] = e_inst[c-1];
    end
    if (fin) begin
      for (int d = 0; d < FL; d++) e_busy[c+d] = 1;
      e_done[c+FL] = 1;
    end
  endfunction

  function automatic void abort_model(int a);
    hold_from(a + 1, 0);
  endfunction

  function automatic void reset_model(int r);
    for (int c = r; c < MAXC; c++) begin
      e_busy[c] = 0; e_done[c] = 0; e_en1[c] = 0; e_en2[c] = 0;
      e_idx[c] = 0; e_c1[c] = 0; e_inst[c] = 0;
    end
    for (int i = 0; i < NC; i++) begin
      m_c1[i] = 0; m_c2[i] = 0; m_inst[i] = 0; m_len[i] = 0; m_last[i] = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_write(int a, bit last, int len, bit with_start = 0, int sc = 0);
    int w = 0;
    cfg_wr_valid = 1; cfg_wr_addr = 3'(a); cfg_wr_last = last; cfg_wr_len = 8'(len);
    cfg_wr_cb1 = {$urandom, $urandom}; cfg_wr_inst = {$urandom, $urandom}; cfg_wr_cb2 = 16'($urandom);
    while (e_busy[cyc] && w < 3000) begin tick(); w++; end
    if (w >= 3000) chk("write_stall_timeout", 1, 0);
    m_c1[a] = cfg_wr_cb1; m_c2[a] = cfg_wr_cb2; m_inst[a] = cfg_wr_inst;
    m_len[a] = len; m_last[a] = last;
    if (with_start) begin start = 1; start_ctx = 3'(sc); gen(cyc, sc, 0); end
    tick();
    cfg_wr_valid = 0; start = 0;
  endtask

  task automatic do_start(int sc, int lp);
    start = 1; start_ctx = 3'(sc);
`ifdef FPU_SEQ_LOOP_EN
    loop_cnt = 8'(lp);
`endif
    if (!e_busy[cyc]) begin
`ifdef FPU_SEQ_LOOP_EN
      gen(cyc, sc, lp);
`else
      gen(cyc, sc, 0);
`endif
    end
    tick();
    start = 0;
  endtask

  task automatic do_abort();
    abort = 1;
    if (e_busy[cyc]) abort_model(cyc);
    tick();
    abort = 0;
  endtask

  task automatic wait_idle(int bound);
    int n = 0;
    while (e_busy[cyc] && n < bound) begin tick(); n++; end
    if (n >= bound) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    int t, s, nctx, base, dsum;
    reset_model(0);
    repeat (3) tick();
    chk("rst_ready", cfg_wr_ready, 1);
    chk("rst_cb1", config_cb1_o, 0);
    rst_n = 1;
    tick();

    do_write(0, 0, 2); do_write(1, 0, 0); do_write(2, 1, 1);
    t = cyc; do_start(0, 0); wait_idle(100); repeat (2) tick();
    chk("t1_en1_T1", o_en1[t+1], 0); chk("t1_en1_T2", o_en1[t+2], 1);
    chk("t1_en1_T7", o_en1[t+7], 1); chk("t1_en1_T8", o_en1[t+8], 0);
    chk("t1_idx_T4", o_idx[t+4], 0); chk("t1_idx_T5", o_idx[t+5], 1); chk("t1_idx_T7", o_idx[t+7], 2);
    chk("t1_en2_T3", o_en2[t+3], 0); chk("t1_en2_T4", o_en2[t+4], 1);
    chk("t1_en2_T9", o_en2[t+9], 1); chk("t1_en2_T10", o_en2[t+10], 0);
    chk("t1_done_T9", o_done[t+9], 0); chk("t1_done_T10", o_done[t+10], 1);
    chk("t1_busy_T1", o_busy[t+1], 1); chk("t1_busy_T10", o_busy[t+10], 0);

    do_write(7, 0, 0); do_write(0, 1, 0);
    t = cyc; do_start(7, 0); wait_idle(100); repeat (2) tick();
    chk("wrap_idx7", o_idx[t+2], 7); chk("wrap_idx0", o_idx[t+3], 0);
    chk("wrap_done", o_done[t+3+FL+1], 1);

    do_write(0, 1, 4);
    t = cyc; do_start(0, 0); tick(); tick(); do_abort(); repeat (12) tick();
    dsum = 0;
    for (int c = t + 1; c <= t + 12; c++) dsum += int'(o_done[c]);
    chk("abort_en1", o_en1[t+4], 0); chk("abort_en2", o_en2[t+4], 0);
    chk("abort_busy", o_busy[t+4], 0); chk("abort_rdy", o_rdy[t+4], 1);
    chk("abort_no_done", dsum, 0);

    do_write(1, 1, 3);
    t = cyc; do_start(1, 0); tick(); do_start(4, 0);
    do_write(5, 1, 0);
    do_start(5, 0); wait_idle(100); repeat (2) tick();
    chk("busy_start_idx", o_idx[t+5], 1); chk("busy_start_en1", o_en1[t+6], 0);
    chk("stall_rdy", o_rdy[t+6], 0); chk("stall_done", o_done[t+8], 1);
    do_write(6, 1, 1, 1, 6); wait_idle(100);

    t = cyc; do_start(1, 0); tick(); tick();
    rst_n = 0; reset_model(cyc); s = cyc;
    tick(); tick(); rst_n = 1; tick();
    chk("midrst_en1", o_en1[s], 0); chk("midrst_rdy", o_rdy[s], 1); chk("midrst_busy", o_busy[s], 0);
    t = cyc; do_start(3, 0); repeat (12) tick();
    chk("zero_idx3", o_idx[t+2], 3); chk("zero_idx4", o_idx[t+3], 4); chk("zero_idx0", o_idx[t+7], 0);
    do_abort(); repeat (3) tick();

`ifdef FPU_SEQ_LOOP_EN
    do_write(2, 1, 0);
    t = cyc; do_start(2, 2); wait_idle(100); repeat (2) tick();
    chk("loop_en_T4", o_en1[t+4], 1); chk("loop_en_T5", o_en1[t+5], 0);
    chk("loop_done", o_done[t+5+FL], 1);
`endif

    for (int it = 0; it < 30 && cyc < MAXC - 300; it++) begin
      nctx = $urandom_range(1, 4); base = $urandom_range(0, NC - 1);
      for (int k = 0; k < nctx; k++)
        do_write((base + k) % NC, k == nctx - 1, $urandom_range(0, 4));
      do_start(base, $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) do_start($urandom_range(0, NC - 1), 0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 12)) tick();
        do_abort();
      end else wait_idle(400);
      repeat ($urandom_range(0, 3)) tick();
    end
    repeat (FL + 3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_config_sequencer.md
Name: fpu_config_sequencer

Overview:
- Context sequencer that drives the configuration inputs of the FPU datapath tile:
  - crossbar-1 selects
  - crossbar-2 selects
  - 64-bit FU instruction word
  - cb1/cb2 enables
- Holds a small program of configuration contexts, loaded over a valid/ready write port.
- On start, steps through the contexts, holding each for a programmed number of cycles.
- Crossbar-2 selects/enable are delayed by the FU pipeline latency so they align with FU results.

Parameters:
- NUM_CTX, 8, number of stored contexts (power of 2)
- NUM_OUTPUTS_CB1, 16, crossbar-1 output count
- SEL_WIDTH_CB1, 4, crossbar-1 select width per output
- NUM_OUTPUTS_CB2, 4, crossbar-2 output count
- SEL_WIDTH_CB2, 4, crossbar-2 select width per output
- INST_WIDTH, 64, FU instruction word width
- LEN_WIDTH, 8, per-context hold-length width
- FU_LAT, 2, crossbar-1 to FU-output latency in cycles (must be >=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_wr_valid  in  1  context write request
- cfg_wr_ready  out  1  write accepted when valid&ready
- cfg_wr_addr  in  $clog2(NUM_CTX)  context index
- cfg_wr_cb1  in  NUM_OUTPUTS_CB1*SEL_WIDTH_CB1  crossbar-1 selects
- cfg_wr_cb2  in  NUM_OUTPUTS_CB2*SEL_WIDTH_CB2  crossbar-2 selects
- cfg_wr_inst  in  INST_WIDTH  FU instruction
- cfg_wr_len  in  LEN_WIDTH  hold cycles minus 1
- cfg_wr_last  in  1  context ends program
- start  in  1  begin execution (pulse)
- start_ctx  in  $clog2(NUM_CTX)  first context
- abort  in  1  stop immediately
- busy  out  1  sequencer active
- done  out  1  one-cycle completion pulse
- ctx_idx_o  out  $clog2(NUM_CTX)  context currently driven on cb1 side
- config_cb1_o  out  NUM_OUTPUTS_CB1*SEL_WIDTH_CB1  to crossbar-1
- config_all_o  out  INST_WIDTH  to FUs
- cb1_en_o  out  1  crossbar-1 enable
- config_cb2_o  out  NUM_OUTPUTS_CB2*SEL_WIDTH_CB2  to crossbar-2
- cb2_en_o  out  1  crossbar-2 enable

Behaviour:
- Reset: clk is the clock; rst_n is the reset, asynchronous and active-low. Reset clears:
  - all outputs to 0 except cfg_wr_ready=1
  - state to IDLE
  - context memory contents to 0
- Write port:
  - cfg_wr_ready = (state==IDLE).
  - A write occurs on valid&ready and is visible to a start issued in the next cycle or later.
  - Writes while busy are stalled, not dropped.
- States: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - start (with abort low) -> LOAD; latch start_ctx.
  - If start and cfg_wr_valid coincide, the write takes effect first; start is honoured.
- LOAD (1 cycle):
  - Registers context[start_ctx] into config_cb1_o/config_all_o/ctx_idx_o.
  - Loads hold counter with len.
  - Sets cb1_en_o=1 from the next cycle.
  - Start at cycle T -> cb1_en_o high at T+2.
- RUN:
  - Counter decrements each cycle; a context is held len+1 cycles (len=0 -> 1 cycle).
  - On the final cycle with last=0: next context (ctx_idx+1 mod NUM_CTX, wraps NUM_CTX-1 -> 0) is loaded in the same edge, with no bubble.
  - On the final cycle with last=1: cb1_en_o->0 and state -> DRAIN.
- cb2 path:
  - config_cb2_o and cb2_en_o are the cb2 field and cb1_en_o delayed by exactly FU_LAT cycles through a shift pipeline.
- DRAIN:
  - Lasts FU_LAT cycles while the pipeline empties.
  - Then: done=1 for one cycle, busy=0, state=IDLE.
  - busy is high from the LOAD cycle through the last DRAIN cycle.
- Control corner cases:
  - start while busy: ignored.
  - abort (any non-IDLE state): next cycle state=IDLE, cb1_en_o=cb2_en_o=0, cb2 pipeline flushed, no done pulse. Config outputs hold their last values.
  - abort in IDLE: no effect.
- A program with no last=1 context runs indefinitely (wrapping) until abort.
- Asynchronous reset mid-run behaves as reset; no done pulse.

Optional Feature:
- Macro FPU_SEQ_LOOP_EN.
- Defined:
  - Adds input loop_cnt [LEN_WIDTH-1:0], sampled at start.
  - On a last=1 context, if the iteration count is below loop_cnt, control returns to start_ctx with no bubble instead of entering DRAIN.
  - The program executes loop_cnt+1 times.
- Undefined: port absent; single pass.

Decomposition:
- Package fpu_seq_pkg holds:
  - ctx_t packed struct {cb1, cb2, inst, len, last}
  - state_t enum
  - width localparams derived from defaults
- Sub-module fpu_seq_ctx_mem:
  - NUM_CTX x ctx_t register file
  - one synchronous write port, one combinational read port, async reset
- The FSM, counters and cb2 delay pipeline live in the top module.

Test Plan:
- Write ctx0 (len=2), ctx1 (len=0), ctx2 (len=1, last=1); start at T with start_ctx=0 -> cb1_en_o high T+2..T+7; ctx_idx_o 0,0,0,1,2,2; cb2_en_o high T+4..T+9 (FU_LAT=2); done at T+10.
- Program ctx7 (len=0), ctx0 (len=0, last=1); start_ctx=7 -> ctx_idx_o 7 then 0 (wrap); done after FU_LAT drain.
- Issue abort in the second RUN cycle -> next cycle cb1_en_o=cb2_en_o=0, busy=0, done never asserted; cfg_wr_ready=1.
- cfg_wr_valid held during a run -> cfg_wr_ready=0 until IDLE, then write accepted; start pulsed while busy -> no restart, ctx_idx_o unchanged.
- Assert rst_n low mid-RUN -> all outputs 0, cfg_wr_ready=1; subsequent start reads zeroed contexts (len=0, last=0) and runs until abort.
- With FPU_SEQ_LOOP_EN, loop_cnt=2, a single context (len=0, last=1) -> cb1_en_o high 3 consecutive cycles, then one done.
